rr_spill_arbiter: RTL and testbench

Round-robin arbiter that shares one registered output stream between `NumInp` valid/ready requesters. Arbitration is combinational on the input side. The winner is captured into a two-slot spill buffer, so every output is driven from a flop and no combinational path runs from `oup_ready_i` to any `inp_ready_o`. It sits wherever several stream sources feed one downstream port and a timing cut is needed at the merge point.

---
 rtl/rr_spill_arbiter.sv | 152 +++++++++++++++
 tb/tb_rr_spill_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_spill_arbiter.sv
// Round-robin merge of NumInp valid/ready streams into one output stream.
// Winner lands in a two-slot spill buffer, so all outputs come from flops.
module rr_spill_arbiter #(
  parameter int unsigned NumInp = 2,
  parameter type         T      = logic,
  parameter bit          LockIn = 1'b1,
  parameter int unsigned IdxW   = $clog2(NumInp)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   flush_i,
  input  logic [NumInp-1:0]      inp_valid_i,
  output logic [NumInp-1:0]      inp_ready_o,
  input  T     [NumInp-1:0]      inp_data_i,
  output logic                   oup_valid_o,
  input  logic                   oup_ready_i,
  output T                       oup_data_o,
  output logic [IdxW-1:0]        oup_idx_o
);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [IdxW:0]   idx_ext_t;

  // Valid/ready: a transfer happens on a rising clock edge where valid and
  // ready are both high; valid must not drop while a locked grant waits.

  idx_t rr_q;
  logic lock_q;
  idx_t lock_idx_q;

  // Slot A drives the output; slot B holds the overflow item when A stalls.
  logic a_full_q;
  T     a_data_q;
  idx_t a_idx_q;
  logic b_full_q;
  T     b_data_q;
  idx_t b_idx_q;

  idx_t     rr_winner;
  logic     rr_found;
  idx_ext_t cand_sum;
  idx_t     cand;
  idx_t     win_idx;
  idx_t     next_rr;
  logic     win_valid;
  logic     accept;
  logic     drain;
  T         win_data;

  // Scan rr_q, rr_q+1, ... wrapping at NumInp rather than 2^IdxW.
  always_comb begin
    rr_winner = rr_q;
    rr_found  = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NumInp; k++) begin
      cand_sum = {1'b0, rr_q} + idx_ext_t'(k);
      if (cand_sum >= idx_ext_t'(NumInp)) begin
        cand_sum = cand_sum - idx_ext_t'(NumInp);
      end
      cand = cand_sum[IdxW-1:0];
      if (!rr_found && inp_valid_i[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
    end
  end

  always_comb begin
    win_idx     = (LockIn && lock_q) ? lock_idx_q : rr_winner;
    win_valid   = inp_valid_i[win_idx];
    win_data    = inp_data_i[win_idx];
    accept      = win_valid && !b_full_q && !flush_i && !clr_i;
    drain       = a_full_q && oup_ready_i;
    next_rr     = (win_idx == idx_t'(NumInp - 1)) ? '0 : win_idx + idx_t'(1);
    inp_ready_o = '0;
    if (accept) begin
      inp_ready_o[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      a_full_q   <= 1'b0;
      a_data_q   <= '0;
      a_idx_q    <= '0;
      b_full_q   <= 1'b0;
      b_data_q   <= '0;
      b_idx_q    <= '0;
    end else if (clr_i) begin
      rr_q     <= '0;
      lock_q   <= 1'b0;
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
    end else if (flush_i) begin
      lock_q   <= 1'b0;
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
    end else begin
      if (accept) begin
        rr_q <= next_rr;
      end

      if (accept) begin
        lock_q <= 1'b0;
      end else if (LockIn && win_valid && b_full_q) begin
        lock_q     <= 1'b1;
        lock_idx_q <= win_idx;
      end

      // accept implies B is empty, so the refill-from-B and accept cases never overlap
      if (accept && (!a_full_q || drain)) begin
        a_full_q <= 1'b1;
        a_data_q <= win_data;
        a_idx_q  <= win_idx;
      end else if (drain && b_full_q) begin
        a_full_q <= 1'b1;
        a_data_q <= b_data_q;
        a_idx_q  <= b_idx_q;
      end else if (drain) begin
        a_full_q <= 1'b0;
      end

      if (accept && a_full_q && !drain) begin
        b_full_q <= 1'b1;
        b_data_q <= win_data;
        b_idx_q  <= win_idx;
      end else if (drain) begin
        b_full_q <= 1'b0;
      end
    end
  end

  assign oup_valid_o = a_full_q;
  assign oup_data_o  = a_data_q;
  assign oup_idx_o   = a_idx_q;

`ifndef SYNTHESIS
  ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(inp_ready_o));

  if (LockIn) begin : g_lock_check
    lock_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (lock_q && !flush_i && !clr_i) |-> inp_valid_i[lock_idx_q]);
  end
`endif

endmodule

// File: tb/tb_rr_spill_arbiter.sv
// Bench for rr_spill_arbiter: hand-derived vector table, streaming and reset
// sequences, and a random phase, all scored against a queue-based model.
module tb_rr_spill_arbiter;

  localparam int N = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            clr_i;
  logic            flush_i;
  logic [N-1:0]    inp_valid_i;
  logic [N-1:0]    inp_ready_o;
  logic [N-1:0][7:0] inp_data_i;
  logic            oup_valid_o;
  logic            oup_ready_i;
  logic [7:0]      oup_data_o;
  logic [1:0]      oup_idx_o;

  rr_spill_arbiter #(
    .NumInp(N),
    .T     (logic [7:0]),
    .LockIn(1'b1)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .flush_i    (flush_i),
    .inp_valid_i(inp_valid_i),
    .inp_ready_o(inp_ready_o),
    .inp_data_i (inp_data_i),
    .oup_valid_o(oup_valid_o),
    .oup_ready_i(oup_ready_i),
    .oup_data_o (oup_data_o),
    .oup_idx_o  (oup_idx_o)
  );

  // Clock and watchdog.
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state: exp_q holds {idx, data} in acceptance order.
  logic [9:0] exp_q[$];
  int         m_rr;
  bit         m_lock;
  int         m_lock_idx;
  int         seq[N];
  logic [7:0] base[N];
  int         drained;
  int         checks;
  int         errors;

  typedef struct {
    logic [3:0] v;
    logic       ordy;
    logic       fl;
    logic       cl;
    logic [3:0] x_ready;
    logic       x_ovalid;
  } vec_t;

  vec_t tbl[32];
  int   n_tbl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic ordy, input logic fl, input logic cl,
                     input logic [3:0] x_ready, input logic x_ovalid);
    tbl[n_tbl] = '{v, ordy, fl, cl, x_ready, x_ovalid};
    n_tbl++;
  endtask

  function automatic int model_winner(input logic [3:0] v);
    int c;
    if (m_lock) return m_lock_idx;
    for (int k = 0; k < N; k++) begin
      c = (m_rr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_rr   = 0;
    m_lock = 1'b0;
    m_lock_idx = 0;
  endtask

  // Driver: one clock cycle of stimulus, checked against the model and,
  // when hand is set, against the hand-derived table expectations.
  task automatic cycle(input logic [3:0] v, input logic ordy, input logic fl, input logic cl,
                       input bit hand, input logic [3:0] x_ready, input logic x_ovalid);
    int         w;
    bit         acc;
    bit         drn;
    bit         bfull;
    logic [3:0] e_ready;
    inp_valid_i = v;
    oup_ready_i = ordy;
    flush_i     = fl;
    clr_i       = cl;
    for (int i = 0; i < N; i++) inp_data_i[i] = base[i] + 8'(seq[i]);
    #2;
    w       = model_winner(v);
    bfull   = (exp_q.size() == 2);
    acc     = (w >= 0) && v[w] && !bfull && !fl && !cl;
    e_ready = acc ? 4'(1 << w) : 4'b0;
    drn     = (exp_q.size() > 0) && ordy;
    chk("inp_ready", 32'(inp_ready_o), 32'(e_ready));
    chk("oup_valid", 32'(oup_valid_o), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("oup_item", 32'({oup_idx_o, oup_data_o}), 32'(exp_q[0]));
    chk("rr_ptr", 32'(dut.rr_q), 32'(m_rr));
    chk("lock", 32'(dut.lock_q), 32'(m_lock));
    if (m_lock) chk("lock_idx", 32'(dut.lock_idx_q), 32'(m_lock_idx));
    chk("b_full", 32'(dut.b_full_q), 32'(bfull));
    if (hand) begin
      chk("tbl_ready", 32'(inp_ready_o), 32'(x_ready));
      chk("tbl_oup_valid", 32'(oup_valid_o), 32'(x_ovalid));
    end
    @(posedge clk_i);
    if (drn) drained++;
    if (cl) begin
      model_reset();
    end else if (fl) begin
      exp_q.delete();
      m_lock = 1'b0;
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({2'(w), inp_data_i[w]});
        seq[w]++;
        m_rr   = (w + 1) % N;
        m_lock = 1'b0;
      end else if ((w >= 0) && v[w] && bfull) begin
        m_lock     = 1'b1;
        m_lock_idx = w;
      end
    end
    #1;
  endtask

  initial begin
    logic [3:0] rv;
    checks = 0;
    errors = 0;
    drained = 0;
    n_tbl = 0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      seq[i]  = 0;
      base[i] = 8'hA0 + 8'(i * 16);
    end

    // Backpressure with grant lock.
    add(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    add(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1);
    add(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    add(4'b0011, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    add(4'b0011, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    add(4'b0011, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
    add(4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    // Flush with both slots full; pointer survives.
    add(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    add(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1);
    add(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    add(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    // Clear mid-stream resets the pointer.
    add(4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    add(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1);
    add(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    add(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    // Contention 0,1,3 with simultaneous accept and drain.
    add(4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
    add(4'b1011, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    add(4'b1011, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1);
    add(4'b1011, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1);
    add(4'b1011, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
    add(4'b1011, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1);
    add(4'b1011, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Reset state.
    rst_ni      = 1'b0;
    clr_i       = 1'b0;
    flush_i     = 1'b0;
    oup_ready_i = 1'b0;
    inp_valid_i = '0;
    inp_data_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_oup_valid", 32'(oup_valid_o), 32'd0);
    chk("rst_oup_data", 32'(oup_data_o), 32'd0);
    chk("rst_oup_idx", 32'(oup_idx_o), 32'd0);
    chk("rst_rr", 32'(dut.rr_q), 32'd0);
    chk("rst_lock", 32'(dut.lock_q), 32'd0);
    chk("rst_ready_idle", 32'(inp_ready_o), 32'd0);
    inp_valid_i = 4'b0100;
    #1;
    chk("rst_ready_onehot", 32'(inp_ready_o), 32'b0100);
    inp_valid_i = '0;
    rst_ni = 1'b1;

    for (int r = 0; r < n_tbl; r++) begin
      cycle(tbl[r].v, tbl[r].ordy, tbl[r].fl, tbl[r].cl, 1'b1, tbl[r].x_ready, tbl[r].x_ovalid);
    end

    // Single-source streaming from input 2.
    for (int i = 0; i < N; i++) seq[i] = 0;
    base[2] = 8'h10;
    drained = 0;
    for (int i = 0; i < 8; i++) cycle(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    repeat (2) cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    chk("stream_drained", 32'(drained), 32'd8);
    chk("stream_rr_end", 32'(dut.rr_q), 32'd3);

    // Random traffic with occasional flush and clear.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) base[i] = 8'($urandom);
      rv = 4'($urandom_range(0, 15));
      if (m_lock) rv[m_lock_idx] = 1'b1;
      cycle(rv, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 49) == 0, 1'b0, 4'b0, 1'b0);
    end
    for (int c = 0; c < 6; c++) begin
      rv = m_lock ? 4'(1 << m_lock_idx) : 4'b0;
      cycle(rv, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    end

    // Asynchronous reset with both slots full.
    cycle(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    inp_valid_i = '0;
    #1;
    chk("pre_reset_valid", 32'(oup_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("async_reset_valid", 32'(oup_valid_o), 32'd0);
    chk("async_reset_rr", 32'(dut.rr_q), 32'd0);
    chk("async_reset_b_full", 32'(dut.b_full_q), 32'd0);
    inp_valid_i = 4'b0100;
    #1;
    chk("async_reset_ready", 32'(inp_ready_o), 32'b0100);
    model_reset();
    @(posedge clk_i);
    #1;
    inp_valid_i = '0;
    rst_ni = 1'b1;
    cycle(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
